// File: rtl/store_trace_buffer_pkg.sv
// Shared widths, limits and the trace entry layout for the store trace buffer.
// The optional per-entry timestamp is enabled with STORE_TRACE_TIMESTAMP_EN.
package store_trace_pkg;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_TS_W   = 16;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  // Entry layout at the default widths; the FIFO word packs fields in this order.
  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [DEFAULT_TS_W-1:0]   ts;
`endif
  } trace_entry_t;

endpackage

// File: rtl/store_trace_buffer_if.sv
// Valid/ready drain port of the store trace buffer: the buffer is master,
// the host-side consumer is slave.
interface store_trace_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16
);
  logic              trace_valid;
  logic              trace_ready;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [TS_W-1:0]   trace_time;

  modport master (output trace_valid, trace_addr, trace_data, trace_time,
                  input  trace_ready);
  modport slave  (input  trace_valid, trace_addr, trace_data, trace_time,
                  output trace_ready);
endinterface

// File: rtl/store_trace_buffer_fifo.sv
// Generic show-ahead synchronous FIFO with clear; pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr, rdPtr;
  logic             doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign level  = wrPtr - rdPtr;
  assign rdata  = mem[rdPtr[AW-1:0]];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; consumers mask the head while empty.
  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_trace_buffer.sv
// Captures core data-memory stores into a FIFO and drains them over a
// valid/ready port. Define STORE_TRACE_TIMESTAMP_EN to timestamp each entry.
module store_trace_buffer
  import store_trace_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TS_W   = DEFAULT_TS_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWrite,
  input  logic [ADDR_W-1:0]         DataAdr,
  input  logic [DATA_W-1:0]         WriteData,
  input  logic                      capture_en,
  input  logic                      clear,
  store_trace_buffer_if.master      trace,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

`ifdef STORE_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = ADDR_W + DATA_W + TS_W;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

  logic [ENTRY_W-1:0] wrEntry, rdEntry;
  logic               fifoFull, fifoEmpty;
  logic               pushReq, popReq, dropNow;

  assign pushReq = MemWrite && capture_en && !clear;
  assign popReq  = trace.trace_valid && trace.trace_ready && !clear;
  // A same-cycle pop frees the slot, so a full FIFO only drops without one.
  assign dropNow = pushReq && fifoFull && !popReq;

  trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq),
    .pop   (popReq),
    .clear (clear),
    .wdata (wrEntry),
    .rdata (rdEntry),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (level)
  );

  assign trace.trace_valid = !fifoEmpty;
  assign trace.trace_addr  = trace.trace_valid ? rdEntry[ENTRY_W-1 -: ADDR_W] : '0;
  assign trace.trace_data  = trace.trace_valid ? rdEntry[ENTRY_W-ADDR_W-1 -: DATA_W] : '0;

`ifdef STORE_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] tsCount;

  // Free-running; clear leaves it alone so timestamps stay comparable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tsCount <= '0;
    else       tsCount <= tsCount + 1'b1;
  end

  assign wrEntry          = {DataAdr, WriteData, tsCount};
  assign trace.trace_time = trace.trace_valid ? rdEntry[TS_W-1:0] : '0;
`else
  assign wrEntry          = {DataAdr, WriteData};
  assign trace.trace_time = {TS_W{1'b0}};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (dropNow) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Self-checking bench for store_trace_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_store_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TS_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemWrite, capture_en, clear;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        level;
  logic              overflow;
  logic [7:0]        drop_cnt;

  store_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W)) tr ();

  store_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .capture_en (capture_en),
    .clear      (clear),
    .trace      (tr),
    .level      (level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

`ifdef STORE_TRACE_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue of captured stores.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          ts;
  } rec_t;

  rec_t q[$];
  bit   mOvf, everPushed;
  int   mDrop, mTs;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mOvf = 0; mDrop = 0; mTs = 0; everPushed = 0;
    end else begin
      if (clear) begin
        q.delete();
        mOvf = 0; mDrop = 0;
      end else begin
        if (q.size() > 0 && tr.trace_ready) void'(q.pop_front());
        if (MemWrite && capture_en) begin
          if (q.size() < DEPTH) begin
            q.push_back('{a: DataAdr, d: WriteData, ts: TS_ON ? mTs : 0});
            everPushed = 1;
          end else begin
            mOvf = 1;
            if (mDrop < 255) mDrop++;
          end
        end
      end
      mTs = (mTs + 1) % (1 << TS_W);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("valid", 64'(tr.trace_valid), 64'(q.size() != 0));
      check("level", 64'(level), 64'(q.size()));
      check("overflow", 64'(overflow), 64'(mOvf));
      check("drop_cnt", 64'(drop_cnt), 64'(mDrop));
      if (q.size() != 0) begin
        check("head_addr", 64'(tr.trace_addr), 64'(q[0].a));
        check("head_data", 64'(tr.trace_data), 64'(q[0].d));
        check("head_time", 64'(tr.trace_time), 64'(q[0].ts));
      end else if (!everPushed) begin
        check("empty_addr", 64'(tr.trace_addr), 64'd0);
        check("empty_data", 64'(tr.trace_data), 64'd0);
        check("empty_time", 64'(tr.trace_time), 64'd0);
      end
    end
  end

  // Called at a negedge: apply inputs, pass one rising edge, return at next negedge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
    MemWrite = mw; DataAdr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    capture_en = 1'b1; clear = 1'b0; tr.trace_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(tr.trace_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    reset = 1'b0;

    // Timestamps: captures on edges 3 and 20 after reset (20 wraps to 4).
    repeat (3) step(1'b0, 0, 0);
    step(1'b1, 32'hA0, 32'h11);
    repeat (16) step(1'b0, 0, 0);
    step(1'b1, 32'hA4, 32'h22);
    check("ts_level", 64'(level), 64'd2);
    check("ts_first", 64'(tr.trace_time), TS_ON ? 64'd3 : 64'd0);
    tr.trace_ready = 1'b1;
    step(1'b0, 0, 0);
    check("ts_second_data", 64'(tr.trace_data), 64'h22);
    check("ts_second", 64'(tr.trace_time), TS_ON ? 64'd4 : 64'd0);
    step(1'b0, 0, 0);

    // Single store with a ready consumer.
    step(1'b1, 32'h64, 32'h7);
    check("single_valid", 64'(tr.trace_valid), 64'd1);
    check("single_addr", 64'(tr.trace_addr), 64'h64);
    check("single_data", 64'(tr.trace_data), 64'h7);
    step(1'b0, 0, 0);
    check("single_drained", 64'(level), 64'd0);

    // Fill, overflow by three, then push+pop while full.
    tr.trace_ready = 1'b0;
    for (int i = 1; i <= 16; i++) step(1'b1, 32'h100 + 4 * i, i);
    check("full_level", 64'(level), 64'd16);
    check("full_no_ovf", 64'(overflow), 64'd0);
    for (int i = 1; i <= 3; i++) step(1'b1, 32'h200 + i, 32'h100 + i);
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd3);
    check("ovf_head", 64'(tr.trace_data), 64'd1);
    tr.trace_ready = 1'b1;
    step(1'b1, 32'h999, 32'h99);
    check("fullpp_level", 64'(level), 64'd16);
    check("fullpp_drop", 64'(drop_cnt), 64'd3);
    for (int i = 2; i <= 16; i++) begin
      check("drain_order", 64'(tr.trace_data), 64'(i));
      step(1'b0, 0, 0);
    end
    check("drain_last", 64'(tr.trace_data), 64'h99);
    step(1'b0, 0, 0);
    check("drain_empty", 64'(level), 64'd0);

    // Capture disabled.
    capture_en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + i, i);
    check("cen_level", 64'(level), 64'd0);
    check("cen_valid", 64'(tr.trace_valid), 64'd0);
    capture_en = 1'b1;

    // Clear with level 10 and four drops while a store arrives.
    clear = 1'b1; step(1'b0, 0, 0); clear = 1'b0;
    tr.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 32'h400 + i, 32'h40 + i);
    tr.trace_ready = 1'b1;
    repeat (6) step(1'b0, 0, 0);
    check("preclr_level", 64'(level), 64'd10);
    check("preclr_drop", 64'(drop_cnt), 64'd4);
    tr.trace_ready = 1'b0;
    clear = 1'b1; step(1'b1, 32'h500, 32'h50); clear = 1'b0;
    check("clr_level", 64'(level), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);

    // Drop counter saturation.
    for (int i = 0; i < 16 + 260; i++) step(1'b1, 32'h600 + i, i);
    check("sat_drop", 64'(drop_cnt), 64'd255);
    check("sat_level", 64'(level), 64'd16);

    // Asynchronous reset mid-operation, then capture on the first edge after.
    #2 reset = 1'b1;
    #1;
    check("arst_level", 64'(level), 64'd0);
    check("arst_valid", 64'(tr.trace_valid), 64'd0);
    check("arst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'h700, 32'h77);
    check("post_rst_level", 64'(level), 64'd1);
    check("post_rst_data", 64'(tr.trace_data), 64'h77);
    check("post_rst_time", 64'(tr.trace_time), 64'd0);
    repeat (2) step(1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_trace_buffer.md
# store_trace_buffer

Captures every data-memory store issued by the single-cycle ARM core (`MemWrite`, `DataAdr`, `WriteData` out of `top`) into a small FIFO and drains the entries through a valid/ready port. It sits directly downstream of the processor's memory interface, alongside data memory. Benches and a host-side checker use it to read the store sequence in order, without probing the core's internals.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `ADDR_W`, 32: captured address width.
- `DATA_W`, 32: captured data width.
- `TS_W`, 16: timestamp width.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `MemWrite` input 1: store strobe from core.
- `DataAdr` input `ADDR_W`: store address.
- `WriteData` input `DATA_W`: store data.
- `capture_en` input 1: stores are captured only while 1.
- `clear` input 1: synchronous flush of FIFO, `overflow`, `drop_cnt`.
- `trace_valid` output 1: head entry available.
- `trace_ready` input 1: consumer accepts head.
- `trace_addr` output `ADDR_W`: head address.
- `trace_data` output `DATA_W`: head data.
- `trace_time` output `TS_W`: head timestamp; 0 when feature compiled out.
- `level` output `$clog2(DEPTH)+1`: entries held.
- `overflow` output 1: sticky, a store was dropped.
- `drop_cnt` output 8: dropped stores, saturating at 255.

## Operation
- Push condition: `MemWrite && capture_en && !clear` at a rising edge.
- Pop condition: `trace_valid && trace_ready && !clear`.
- Head outputs are driven from FIFO storage at the read pointer (show-ahead). `trace_valid` is `level != 0`.
- Pointers are `$clog2(DEPTH)+1` bits and wrap naturally. Full is the MSBs differing with the low bits equal. Empty is pointers equal.
- Full, push, no pop: the entry is dropped, `overflow` is set, and `drop_cnt` increments (stays at 255 once there).
- Full, push and pop in the same cycle: both are accepted, `level` is unchanged, and no drop is recorded.
- Empty, push and pop in the same cycle: the pop is impossible because `trace_valid` is 0, so only the push happens.
- `clear` takes priority over push and pop. Pointers, `level`, `overflow` and `drop_cnt` go to 0 next edge. The timestamp counter is not affected.
- While `trace_valid` is 1 and `trace_ready` is 0, the head outputs stay stable.

## Timing
- Reset values:
  - `trace_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0.
  - `trace_addr`, `trace_data`, `trace_time` = 0 while empty after reset.
  - Timestamp counter = 0.
- Capture latency: a store sampled at edge N appears on `trace_valid`/head outputs after edge N, so the consumer can see it in cycle N+1.
- Throughput: one push and one pop per cycle.
- `reset` asserted mid-operation discards all entries immediately (asynchronous). The first capture possible is on the first rising edge with `reset` low.

## Configuration
- `STORE_TRACE_TIMESTAMP_EN` defined:
  - A `TS_W`-bit free-running cycle counter runs from 0 after reset, +1 per edge, wrapping 2^TS_W−1 → 0.
  - Each entry stores the counter value present in its capture cycle, and `trace_time` shows the head's value.
- Undefined: no counter and no timestamp storage; `trace_time` is tied to 0.

## Structure
- Package `store_trace_pkg`:
  - default widths;
  - `trace_entry_t` packed struct (addr, data, optional time);
  - `DROP_CNT_MAX` = 255.
- Sub-module `trace_fifo`: generic synchronous FIFO with push/pop/clear/full/empty/level, parameterised by width and depth.
- The top level adds capture gating, overflow/drop logic and the timestamp counter.

## Test plan
- Reset, then single store DataAdr=0x00000064, WriteData=0x00000007 with `trace_ready`=1 → `trace_valid`=1 for one cycle next cycle, addr 0x64, data 7, `level` returns 0.
- 16 back-to-back stores (data 1..16), `trace_ready`=0, then 3 more → `level`=16, `overflow`=1, `drop_cnt`=3. Draining yields data 1..16 in order.
- Full FIFO with `trace_ready`=1 and a store in the same cycle → `level` stays 16 and `drop_cnt` is unchanged.
- `capture_en`=0 during 5 stores → `level`=0 and `trace_valid` stays 0.
- `clear` pulsed with `level`=10 and `drop_cnt`=4 while a store arrives → next cycle `level`=0, `overflow`=0, `drop_cnt`=0.
- With `STORE_TRACE_TIMESTAMP_EN`, `TS_W`=4: stores at cycles 3 and 20 after reset → `trace_time` 3 and 4 (wrap). Without the macro → `trace_time`=0 for both.
